// File: rtl/srt_div_pkg.sv
// Shared types and sizing helpers for the radix-4 SRT mantissa divider.
package srt_div_pkg;

    typedef logic signed [2:0] srt_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        CORR = 2'd2
    } srt_state_e;

    function automatic int srt_n_iter(input int mant_w);
        return (mant_w + 5) / 2;
    endfunction

endpackage

// File: rtl/srt4_mant_divider_if.sv
// Start/done handshake and result bus of the SRT mantissa divider.
interface srt4_mant_divider_if #(
    parameter int MANT_W = 24
);
    localparam int Q_W = 2 * srt_div_pkg::srt_n_iter(MANT_W);

    logic              start;
    logic [MANT_W-1:0] dividend;
    logic [MANT_W-1:0] divisor;
    logic              busy;
    logic              done;
    logic [Q_W-1:0]    quotient;
    logic              sticky;
    logic              div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, sticky, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, sticky, div_by_zero
    );

endinterface

// File: rtl/srt4_qsel.sv
// Radix-4 quotient digit selection: truncated estimate of 4w (1/16 resolution)
// against four divisor-dependent thresholds, giving a digit in {-2..2}.
module srt4_qsel
    import srt_div_pkg::*;
(
    input  logic signed [6:0] est,
    input  logic        [2:0] d_idx,
    output srt_digit_t        digit
);

    logic signed [6:0] m_p2;
    logic signed [6:0] m_p1;
    logic signed [6:0] m_z;
    logic signed [6:0] m_n1;

    // Thresholds in units of 1/16; each interval d' in [0.5+i/16, 0.5+(i+1)/16)
    // keeps |w| <= 2/3 d' given an estimate that truncates toward -inf.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        m_p2 = 7'sd12;
        m_p1 = 7'sd4;
        m_z  = -7'sd4;
        m_n1 = -7'sd13;
        case (d_idx)
            3'd0: begin m_p2 = 7'sd12; m_p1 = 7'sd4; m_z = -7'sd4; m_n1 = -7'sd13; end
            3'd1: begin m_p2 = 7'sd14; m_p1 = 7'sd4; m_z = -7'sd5; m_n1 = -7'sd15; end
            3'd2: begin m_p2 = 7'sd16; m_p1 = 7'sd5; m_z = -7'sd5; m_n1 = -7'sd16; end
            3'd3: begin m_p2 = 7'sd17; m_p1 = 7'sd5; m_z = -7'sd6; m_n1 = -7'sd17; end
            3'd4: begin m_p2 = 7'sd19; m_p1 = 7'sd6; m_z = -7'sd6; m_n1 = -7'sd19; end
            3'd5: begin m_p2 = 7'sd20; m_p1 = 7'sd6; m_z = -7'sd7; m_n1 = -7'sd20; end
            3'd6: begin m_p2 = 7'sd22; m_p1 = 7'sd7; m_z = -7'sd7; m_n1 = -7'sd22; end
            default: begin m_p2 = 7'sd23; m_p1 = 7'sd8; m_z = -7'sd8; m_n1 = -7'sd24; end
        endcase

        if (est >= m_p2)      digit = 3'sd2;
        else if (est >= m_p1) digit = 3'sd1;
        else if (est >= m_z)  digit = 3'sd0;
        else if (est >= m_n1) digit = -3'sd1;
        else                  digit = -3'sd2;
    end

endmodule

// File: rtl/srt4_mant_divider.sv
// Sequential radix-4 SRT mantissa divider: quotient floor(X*2^(Q_W-2)/D) with
// sticky bit, on-the-fly Q/QM conversion and a final negative-remainder correction.
module srt4_mant_divider
    import srt_div_pkg::*;
#(
    parameter int MANT_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    srt4_mant_divider_if.slave bus
);

    localparam int N_ITER = srt_n_iter(MANT_W);
    localparam int Q_W    = 2 * N_ITER;
    // Remainder: sign + 2 integer bits + MANT_W+2 fraction bits (w0 = X, d' = D<<2).
    localparam int W_W    = MANT_W + 5;
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

    srt_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [W_W-1:0]   w_q, w_d;
    logic signed [W_W-1:0]   dp_q, dp_d;
    logic [Q_W-1:0]          q_q, q_d;
    logic [Q_W-1:0]          qm_q, qm_d;
    logic                    dbz_q, dbz_d;
    logic [Q_W-1:0]          quot_q, quot_d;
    logic                    sticky_q, sticky_d;
    logic                    div_by_zero_q, div_by_zero_d;
    logic                    done_q, done_d;

    logic signed [W_W-1:0]   w4;
    logic signed [W_W-1:0]   qd;
    logic signed [W_W-1:0]   w_next;
    logic signed [W_W-1:0]   w_corr;
    logic [Q_W-1:0]          q_next;
    logic [Q_W-1:0]          qm_next;
    srt_digit_t              digit;

    assign w4 = w_q <<< 2;

    srt4_qsel u_qsel (
        .est   (w4[W_W-1 -: 7]),
        .d_idx (dp_q[MANT_W -: 3]),
        .digit (digit)
    );

    // Digit multiple, next partial remainder and on-the-fly conversion, where QM tracks Q - 1 ulp.
    always_comb begin
        qd      = '0;
        q_next  = q_q;
        qm_next = qm_q;
        case (digit)
            3'sd2: begin
                qd      = dp_q <<< 1;
                q_next  = {q_q[Q_W-3:0], 2'd2};
                qm_next = {q_q[Q_W-3:0], 2'd1};
            end
            3'sd1: begin
                qd      = dp_q;
                q_next  = {q_q[Q_W-3:0], 2'd1};
                qm_next = {q_q[Q_W-3:0], 2'd0};
            end
            3'sd0: begin
                qd      = '0;
                q_next  = {q_q[Q_W-3:0], 2'd0};
                qm_next = {qm_q[Q_W-3:0], 2'd3};
            end
            -3'sd1: begin
                qd      = -dp_q;
                q_next  = {qm_q[Q_W-3:0], 2'd3};
                qm_next = {qm_q[Q_W-3:0], 2'd2};
            end
            -3'sd2: begin
                qd      = -(dp_q <<< 1);
                q_next  = {qm_q[Q_W-3:0], 2'd2};
                qm_next = {qm_q[Q_W-3:0], 2'd1};
            end
            default: begin
                qd      = '0;
                q_next  = q_q;
                qm_next = qm_q;
            end
        endcase
    end

    assign w_next = w4 - qd;
    assign w_corr = w_q[W_W-1] ? (w_q + dp_q) : w_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        w_d           = w_q;
        dp_d          = dp_q;
        q_d           = q_q;
        qm_d          = qm_q;
        dbz_d         = dbz_q;
        quot_d        = quot_q;
        sticky_d      = sticky_q;
        div_by_zero_d = div_by_zero_q;
        done_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    w_d     = {5'b0, bus.dividend};
                    dp_d    = {3'b0, bus.divisor, 2'b0};
                    q_d     = '0;
                    qm_d    = '0;
                    cnt_d   = '0;
                    dbz_d   = (bus.divisor == '0);
                    state_d = (bus.divisor == '0) ? CORR : ITER;
                end
            end
            ITER: begin
                w_d   = w_next;
                q_d   = q_next;
                qm_d  = qm_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) state_d = CORR;
            end
            CORR: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dbz_q) begin
                    quot_d        = '1;
                    sticky_d      = 1'b0;
                    div_by_zero_d = 1'b1;
                end else begin
                    w_d           = w_corr;
                    quot_d        = w_q[W_W-1] ? qm_q : q_q;
                    sticky_d      = |w_corr;
                    div_by_zero_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            w_q           <= '0;
            dp_q          <= '0;
            q_q           <= '0;
            qm_q          <= '0;
            dbz_q         <= 1'b0;
            quot_q        <= '0;
            sticky_q      <= 1'b0;
            div_by_zero_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            w_q           <= w_d;
            dp_q          <= dp_d;
            q_q           <= q_d;
            qm_q          <= qm_d;
            dbz_q         <= dbz_d;
            quot_q        <= quot_d;
            sticky_q      <= sticky_d;
            div_by_zero_q <= div_by_zero_d;
            done_q        <= done_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.sticky      = sticky_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_srt4_mant_divider.sv
// Self-checking bench: directed table, handshake corner cases and random pairs
// for MANT_W=24 and MANT_W=53, checked against an arithmetic reference model.
module tb_srt4_mant_divider;
    import srt_div_pkg::*;

    localparam int N24  = (24 + 5) / 2;
    localparam int N53  = (53 + 5) / 2;
    localparam int QW24 = 2 * N24;

    typedef struct {
        logic [127:0] q;
        logic         sticky;
        logic         dbz;
        int unsigned  done_cyc;
    } exp_t;

    typedef struct {
        logic [23:0]     x;
        logic [23:0]     d;
        logic [QW24-1:0] q;
        logic            sticky;
        logic            dbz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    exp_t        sb24[$];
    exp_t        sb53[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    srt4_mant_divider_if #(.MANT_W(24)) bus24 ();
    srt4_mant_divider_if #(.MANT_W(53)) bus53 ();

    srt4_mant_divider #(.MANT_W(24)) dut24 (.clk(clk), .rst(rst), .bus(bus24));
    srt4_mant_divider #(.MANT_W(53)) dut53 (.clk(clk), .rst(rst), .bus(bus53));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int mw, input logic [127:0] x, input logic [127:0] d);
        exp_t         e;
        int           qw;
        logic [127:0] num;
        qw         = 2 * ((mw + 5) / 2);
        e.done_cyc = 0;
        if (d == 0) begin
            e.q      = (128'd1 << qw) - 128'd1;
            e.sticky = 1'b0;
            e.dbz    = 1'b1;
        end else begin
            num      = x << (qw - 2);
            e.q      = num / d;
            e.sticky = ((num % d) != 0);
            e.dbz    = 1'b0;
        end
        return e;
    endfunction

    function automatic logic inv_ok(input longint w, input longint dp);
        longint aw;
        aw = (w < 0) ? -w : w;
        return (3 * aw <= 2 * dp);
    endfunction

    // Scoreboards: pop and compare on every done; also watch the remainder bound while iterating.
    always @(negedge clk) begin : mon24
        exp_t e;
        if (bus24.done === 1'b1) begin
            if (sb24.size() == 0) begin
                check("spurious_done24", 128'(bus24.done), 128'd0);
            end else begin
                e = sb24.pop_front();
                check("quot24", 128'(bus24.quotient), e.q);
                check("sticky24", 128'(bus24.sticky), 128'(e.sticky));
                check("dbz24", 128'(bus24.div_by_zero), 128'(e.dbz));
                check("lat24", 128'(cyc), 128'(e.done_cyc));
            end
        end
        if (!rst && dut24.state_q == ITER)
            check("inv24", 128'(inv_ok(longint'(dut24.w_q), longint'(dut24.dp_q))), 128'd1);
    end

    always @(negedge clk) begin : mon53
        exp_t e;
        if (bus53.done === 1'b1) begin
            if (sb53.size() == 0) begin
                check("spurious_done53", 128'(bus53.done), 128'd0);
            end else begin
                e = sb53.pop_front();
                check("quot53", 128'(bus53.quotient), e.q);
                check("sticky53", 128'(bus53.sticky), 128'(e.sticky));
                check("dbz53", 128'(bus53.div_by_zero), 128'(e.dbz));
                check("lat53", 128'(cyc), 128'(e.done_cyc));
            end
        end
        if (!rst && dut53.state_q == ITER)
            check("inv53", 128'(inv_ok(longint'(dut53.w_q), longint'(dut53.dp_q))), 128'd1);
    end

    // Called at a falling edge; returns at the falling edge after the start was sampled.
    task automatic issue24(input logic [23:0] x, input logic [23:0] d, input logic [127:0] q,
                           input logic st, input logic dz, input logic push);
        exp_t e;
        e.q        = q;
        e.sticky   = st;
        e.dbz      = dz;
        e.done_cyc = cyc + 1 + ((d == 0) ? 1 : N24 + 1);
        bus24.start    = 1'b1;
        bus24.dividend = x;
        bus24.divisor  = d;
        if (push) sb24.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus24.start = 1'b0;
        check("busy24", 128'(bus24.busy), 128'd1);
    endtask

    task automatic issue53(input logic [52:0] x, input logic [52:0] d);
        exp_t e;
        e          = model(53, 128'(x), 128'(d));
        e.done_cyc = cyc + 1 + ((d == 0) ? 1 : N53 + 1);
        bus53.start    = 1'b1;
        bus53.dividend = x;
        bus53.divisor  = d;
        sb53.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus53.start = 1'b0;
        check("busy53", 128'(bus53.busy), 128'd1);
    endtask

    task automatic drain24(input int budget);
        int n = 0;
        while (sb24.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb24.size() != 0) begin
            check("drain24_timeout", 128'(sb24.size()), 128'd0);
            sb24.delete();
        end
    endtask

    task automatic drain53(input int budget);
        int n = 0;
        while (sb53.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb53.size() != 0) begin
            check("drain53_timeout", 128'(sb53.size()), 128'd0);
            sb53.delete();
        end
    endtask

    task automatic wait_done24(input int budget);
        int n = 0;
        while (bus24.done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus24.done !== 1'b1) check("done24_timeout", 128'(bus24.done), 128'd1);
    endtask

    initial begin
        vec_t        vecs[7];
        exp_t        e;
        logic [23:0] x24, d24;
        logic [52:0] x53, d53;
        logic [31:0] r1, r2;
        logic [63:0] r3, r4;

        vecs[0] = '{24'h800000, 24'h800000, 28'h4000000, 1'b0, 1'b0};
        vecs[1] = '{24'hC00000, 24'h800000, 28'h6000000, 1'b0, 1'b0};
        vecs[2] = '{24'h800000, 24'hC00000, 28'h2AAAAAA, 1'b1, 1'b0};
        vecs[3] = '{24'hFFFFFF, 24'h800000, 28'h7FFFFF8, 1'b0, 1'b0};
        vecs[4] = '{24'h800000, 24'h000000, 28'hFFFFFFF, 1'b0, 1'b1};
        vecs[5] = '{24'h800000, 24'hFFFFFF, 28'h2000002, 1'b1, 1'b0};
        vecs[6] = '{24'hA00000, 24'h800000, 28'h5000000, 1'b0, 1'b0};

        bus24.start = 1'b0; bus24.dividend = '0; bus24.divisor = '0;
        bus53.start = 1'b0; bus53.dividend = '0; bus53.divisor = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_quot", 128'(bus24.quotient), 128'd0);
        check("rst_sticky", 128'(bus24.sticky), 128'd0);
        check("rst_dbz", 128'(bus24.div_by_zero), 128'd0);
        check("rst_busy", 128'(bus24.busy), 128'd0);
        check("rst_done", 128'(bus24.done), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            issue24(vecs[i].x, vecs[i].d, 128'(vecs[i].q), vecs[i].sticky, vecs[i].dbz, 1'b1);
            drain24(4 * N24);
        end

        // Back-to-back: second start lands in the done cycle of the first.
        issue24(24'hC00000, 24'h800000, 128'h6000000, 1'b0, 1'b0, 1'b1);
        wait_done24(4 * N24);
        issue24(24'h800000, 24'hC00000, 128'h2AAAAAA, 1'b1, 1'b0, 1'b1);
        drain24(4 * N24);

        // Start held high while busy with changing operands: only the first is accepted.
        issue24(24'hFFFFFF, 24'h800000, 128'h7FFFFF8, 1'b0, 1'b0, 1'b1);
        bus24.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus24.dividend = 24'h900000 + 24'(i);
            bus24.divisor  = 24'hB00000;
            @(negedge clk);
        end
        bus24.start = 1'b0;
        drain24(4 * N24);
        repeat (N24 + 4) @(negedge clk);
        check("idle_after_hold", 128'(bus24.busy), 128'd0);

        // Reset pulse in the middle of iterating: outputs clear, no done follows.
        issue24(24'hC00000, 24'hA00000, 128'd0, 1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_quot", 128'(bus24.quotient), 128'd0);
        check("midrst_busy", 128'(bus24.busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (N24 + 4) @(negedge clk);
        check("postrst_quot", 128'(bus24.quotient), 128'd0);
        check("postrst_sticky", 128'(bus24.sticky), 128'd0);
        check("postrst_dbz", 128'(bus24.div_by_zero), 128'd0);
        check("postrst_busy", 128'(bus24.busy), 128'd0);

        for (int i = 0; i < 30; i++) begin
            r1  = $urandom();
            r2  = $urandom();
            x24 = {1'b1, r1[22:0]};
            d24 = (i == 7) ? 24'h000000 : {1'b1, r2[22:0]};
            e   = model(24, 128'(x24), 128'(d24));
            issue24(x24, d24, e.q, e.sticky, e.dbz, 1'b1);
            drain24(4 * N24);
        end

        issue53(53'h10000000000000, 53'h10000000000000);
        drain53(4 * N53);
        issue53(53'h1FFFFFFFFFFFFF, 53'h00000000000000);
        drain53(4 * N53);
        for (int i = 0; i < 30; i++) begin
            r3  = {$urandom(), $urandom()};
            r4  = {$urandom(), $urandom()};
            x53 = {1'b1, r3[51:0]};
            d53 = {1'b1, r4[51:0]};
            issue53(x53, d53);
            drain53(4 * N53);
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
